// File: rtl/key_pkg.sv
// Shared types and default timing constants for the pushbutton detector.
package key_pkg;

   localparam int CNT_W      = 26;
   localparam int T_DB_DEF   = 500_000;     // 10 ms at 50 MHz
   localparam int T_LONG_DEF = 50_000_000;  // 1 s at 50 MHz

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      PRESSED    = 2'd2,
      RELEASE_DB = 2'd3
   } key_state_e;

endpackage

// File: rtl/key_detect_module_if.sv
// Button input and event outputs of the key detector.
interface key_detect_module_if;

   logic KEY_In;     // raw button, active-low, asynchronous
   logic H2L_Sig;    // press pulse
   logic L2H_Sig;    // release pulse
   logic Long_Sig;   // long-press pulse
   logic Key_State;  // debounced level, 1 = pressed

   modport master (output KEY_In, input H2L_Sig, L2H_Sig, Long_Sig, Key_State);
   modport slave  (input KEY_In, output H2L_Sig, L2H_Sig, Long_Sig, Key_State);

endinterface

// File: rtl/key_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module key_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic CLK,
   input  logic RST_n,
   input  logic d,
   output logic q
);

   logic s1;

   // Two back-to-back flops; both load RST_VAL so reset looks like an idle line.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         s1 <= RST_VAL;
         q  <= RST_VAL;
      end else begin
         s1 <= d;
         q  <= s1;
      end
   end

endmodule

// File: rtl/key_detect_module.sv
// Debounced pushbutton detector: press/release/long-press pulses and level.
module key_detect_module
   import key_pkg::*;
#(
   parameter int T_DB   = T_DB_DEF,
   parameter int T_LONG = T_LONG_DEF
) (
   input  logic                CLK,
   input  logic                RST_n,
   key_detect_module_if.slave  kif
);

   localparam cnt_t DB_END   = cnt_t'(T_DB);
   localparam cnt_t LONG_END = cnt_t'(T_LONG);
   localparam cnt_t ONE      = cnt_t'(1);

   logic       key_s;
   key_state_e state, state_nx;
   cnt_t       db_cnt, db_nx, long_cnt, long_nx;
   logic       long_done, long_done_nx;
   logic       h2l_q, l2h_q, long_q, key_st_q;
   logic       h2l_nx, l2h_nx, long_sig_nx, key_st_nx;

   key_sync #(.RST_VAL(1'b1)) u_sync (
      .CLK   (CLK),
      .RST_n (RST_n),
      .d     (kif.KEY_In),
      .q     (key_s)
   );

   // State, counters and all outputs are registered together.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state     <= IDLE;
         db_cnt    <= '0;
         long_cnt  <= '0;
         long_done <= 1'b0;
         h2l_q     <= 1'b0;
         l2h_q     <= 1'b0;
         long_q    <= 1'b0;
         key_st_q  <= 1'b0;
      end else begin
         state     <= state_nx;
         db_cnt    <= db_nx;
         long_cnt  <= long_nx;
         long_done <= long_done_nx;
         h2l_q     <= h2l_nx;
         l2h_q     <= l2h_nx;
         long_q    <= long_sig_nx;
         key_st_q  <= key_st_nx;
      end
   end

   // Next-state, debounce counting and long-press tracking.
   always_comb begin
      state_nx     = state;
      db_nx        = db_cnt;
      long_nx      = long_cnt;
      long_done_nx = long_done;
      h2l_nx       = 1'b0;
      l2h_nx       = 1'b0;
      long_sig_nx  = 1'b0;
      key_st_nx    = key_st_q;

      // Hold time keeps running through a release bounce, so a long press
      // that completes while the release is still being debounced counts.
      if ((state == PRESSED || state == RELEASE_DB) && long_cnt != LONG_END) begin
         long_nx = long_cnt + ONE;
         if (long_nx == LONG_END && !long_done) begin
            long_sig_nx  = 1'b1;
            long_done_nx = 1'b1;
         end
      end

      case (state)
         IDLE: begin
            if (!key_s) begin
               state_nx = PRESS_DB;
               db_nx    = ONE;
            end
         end
         PRESS_DB: begin
            if (key_s) begin
               state_nx = IDLE;
               db_nx    = '0;
            end else if (db_cnt + ONE == DB_END) begin
               state_nx     = PRESSED;
               db_nx        = '0;
               h2l_nx       = 1'b1;
               key_st_nx    = 1'b1;
               long_nx      = '0;
               long_done_nx = 1'b0;
            end else begin
               db_nx = db_cnt + ONE;
            end
         end
         PRESSED: begin
            if (key_s) begin
               state_nx = RELEASE_DB;
               db_nx    = ONE;
            end
         end
         RELEASE_DB: begin
            if (!key_s) begin
               state_nx = PRESSED;
               db_nx    = '0;
            end else if (db_cnt + ONE == DB_END) begin
               state_nx  = IDLE;
               db_nx     = '0;
               l2h_nx    = 1'b1;
               key_st_nx = 1'b0;
            end else begin
               db_nx = db_cnt + ONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign kif.H2L_Sig   = h2l_q;
   assign kif.L2H_Sig   = l2h_q;
   assign kif.Long_Sig  = long_q;
   assign kif.Key_State = key_st_q;

endmodule
